// File: rtl/spu_uart_tx_fifo_pkg.sv
// Shared definitions for the SPU UART transmitter: parity encodings, FSM states
// and a helper that derives the baud divisor from clock and baud rate.
package spu_uart_tx_fifo_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   // Rounded to nearest so e.g. 100 MHz / 115200 gives 868.
   function automatic int clk_div_for(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/spu_uart_tx_fifo_if.sv
// Write/status bundle between the SPU IO path and the UART transmitter.
interface spu_uart_tx_fifo_if #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              ovf_clr;
   logic              full;
   logic              empty;
   logic [LVL_W-1:0]  level;
   logic              busy;
   logic              overflow;
   logic              txd;

   modport master (
      output wr_en, wr_data, ovf_clr,
      input  full, empty, level, busy, overflow, txd
   );

   modport slave (
      input  wr_en, wr_data, ovf_clr,
      output full, empty, level, busy, overflow, txd
   );

endinterface

// File: rtl/spu_uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read; shared by the UART TX and RX paths.
module spu_sync_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   localparam int AW        = $clog2(FIFO_DEPTH),
   localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] pop_data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [LW-1:0]     level_o
);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [LW-1:0]     level_q;
   logic              do_push;
   logic              do_pop;

   // Guards use pre-edge full/empty, so a pop never makes room for a same-cycle push.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_q + LW'(do_push) - LW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign pop_data_o = mem_q[rd_ptr_q];
   assign full_o     = (level_q == LW'(FIFO_DEPTH));
   assign empty_o    = (level_q == '0);
   assign level_o    = level_q;

endmodule

// File: rtl/spu_uart_tx_fifo.sv
// Configurable UART transmitter fed by a write-side FIFO; drives the txd pad from a flop.
module spu_uart_tx_fifo
   import spu_uart_tx_fifo_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int CLK_DIV    = 868,
   parameter int FIFO_DEPTH = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic              clk,
   input  logic              rst,
   spu_uart_tx_fifo_if.slave bus
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = 4;
   localparam int LW = $clog2(FIFO_DEPTH + 1);

   tx_state_e         state_q, state_d;
   logic [CW-1:0]     baud_q, baud_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic              txd_q, txd_d;
   logic              ovf_q, ovf_d;
   logic              pop;
   logic              bit_end;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LW-1:0]     fifo_level;

   spu_sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (bus.wr_en),
      .push_data_i (bus.wr_data),
      .pop_i       (pop),
      .pop_data_o  (fifo_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (fifo_level)
   );

   assign bit_end = (baud_q == CW'(CLK_DIV - 1));

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop     = 1'b0;
      txd_d   = 1'b1;
      ovf_d   = ovf_q;

      if (state_q != ST_IDLE) baud_d = bit_end ? '0 : baud_q + CW'(1);

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_START;
               baud_d  = '0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == BW'(DATA_W - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               bit_d   = '0;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (bit_q == BW'(STOP_BITS - 1)) begin
                  bit_d = '0;
                  // Chain straight into the next start bit so queued frames have no idle gap.
                  if (!fifo_empty) begin
                     pop     = 1'b1;
                     state_d = ST_START;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pop) begin
         shift_d = fifo_data;
         par_d   = ^fifo_data;
      end

      // txd is registered, so its next value follows the next state.
      case (state_d)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shift_d[0];
         ST_PARITY: txd_d = (PARITY == PAR_ODD) ? ~par_q : par_q;
         default:   txd_d = 1'b1;
      endcase

      if (bus.ovf_clr) ovf_d = 1'b0;
      if (bus.wr_en && fifo_full) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.full     = fifo_full;
   assign bus.empty    = fifo_empty;
   assign bus.level    = fifo_level;
   assign bus.busy     = (state_q != ST_IDLE) || !fifo_empty;
   assign bus.overflow = ovf_q;
   assign bus.txd      = txd_q;

endmodule
